// File: rtl/serial_readout_ctrl.sv
// serial_readout_ctrl
// Sequences one MRAM read into the 16-bit parallel-to-serial shifter and
// drives its load/shift controls. The FSM runs IDLE -> READ -> LOAD -> SHIFT
// -> DRAIN -> IDLE. Every output is a flop. Each output shows the state that
// was left at the previous edge. Two exceptions act on the edge where they are
// sampled: an abort and a read timeout. Both clear the outputs and raise err.
//
// Optional feature: define SERIAL_READOUT_TIMEOUT_EN to build a READ-phase
// timeout of RD_TIMEOUT cycles. Without it, READ waits for mram_rdy forever.
module serial_readout_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_word_sel,
    input  logic              abort,
    input  logic              mram_rdy,
    output logic              mram_rd,
    output logic [ADDR_W-1:0] mram_addr,
    output logic              ps_en,
    output logic              ps_load,
    output logic              ps_send,
    output logic [1:0]        ps_word_sel,
    output logic              busy,
    output logic              tx_valid,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // Number of serial bits for a word select: full word or a single byte.
    function automatic logic [4:0] bits_for_sel(input logic [1:0] sel);
        logic [4:0] n;
        case (sel)
            2'b11:   n = 5'd16;
            2'b01:   n = 5'd8;
            2'b10:   n = 5'd8;
            default: n = 5'd8;
        endcase
        return n;
    endfunction

    // A word select of 00 names no bytes and is rejected.
    function automatic logic word_sel_legal(input logic [1:0] sel);
        return (sel != 2'b00);
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [4:0]          bit_cnt_r;
    logic [4:0]          bit_cnt_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [1:0]          sel_r;
    logic                capture_s;

    logic                mram_rd_r,  mram_rd_s;
    logic                ps_en_r,    ps_en_s;
    logic                ps_load_r,  ps_load_s;
    logic                ps_send_r,  ps_send_s;
    logic                busy_r,     busy_s;
    logic                tx_valid_r, tx_valid_s;
    logic                done_r,     done_s;
    logic                err_r,      err_s;

    logic                abort_hit_s;
    logic                timeout_hit_s;
    logic                last_bit_s;

`ifdef SERIAL_READOUT_TIMEOUT_EN
    localparam int TO_W = ($clog2(RD_TIMEOUT + 1) < 4) ? 4 : $clog2(RD_TIMEOUT + 1);

    logic [TO_W-1:0] rd_cnt_r;

    // Count the cycles spent in READ. The count restarts whenever the FSM is in another state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_r <= '0;
        end else if (state_r == S_READ) begin
            rd_cnt_r <= rd_cnt_r + TO_W'(1);
        end else begin
            rd_cnt_r <= '0;
        end
    end

    // The timeout fires on the RD_TIMEOUT-th cycle in READ.
    // mram_rdy on that same cycle still takes priority in the FSM.
    assign timeout_hit_s = (state_r == S_READ) && (rd_cnt_r == TO_W'(RD_TIMEOUT - 1));
`else
    // The timeout is compiled out.
    // The parameter is still referenced, but the expression is constant false.
    assign timeout_hit_s = (RD_TIMEOUT < 32'sd0);
`endif

    // An abort matters only while a transaction is in flight.
    assign abort_hit_s = abort && (state_r != S_IDLE);

    // SHIFT ends after the count of bits for the captured word select.
    assign last_bit_s = (bit_cnt_r == (bits_for_sel(sel_r) - 5'd1));

    // Next-state and next-output logic.
    // Outputs describe the current state, except that abort clears them at once.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        capture_s  = 1'b0;
        mram_rd_s  = 1'b0;
        ps_en_s    = 1'b0;
        ps_load_s  = 1'b0;
        ps_send_s  = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        tx_valid_s = ps_send_r;

        if (abort_hit_s) begin
            // Drop everything, including the bit currently on data_out.
            state_s    = S_IDLE;
            err_s      = 1'b1;
            tx_valid_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req) begin
                        if (word_sel_legal(req_word_sel)) begin
                            state_s   = S_READ;
                            capture_s = 1'b1;
                            busy_s    = 1'b1;
                        end else begin
                            err_s     = 1'b1;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_READ: begin
                    mram_rd_s = 1'b1;
                    ps_en_s   = 1'b1;
                    busy_s    = 1'b1;
                    if (mram_rdy) begin
                        state_s = S_LOAD;
                    end else if (timeout_hit_s) begin
                        state_s   = S_IDLE;
                        err_s     = 1'b1;
                        mram_rd_s = 1'b0;
                        ps_en_s   = 1'b0;
                        busy_s    = 1'b0;
                    end else begin
                        state_s = S_READ;
                    end
                end
                S_LOAD: begin
                    ps_load_s = 1'b1;
                    ps_en_s   = 1'b1;
                    busy_s    = 1'b1;
                    bit_cnt_s = 5'd0;
                    state_s   = S_SHIFT;
                end
                S_SHIFT: begin
                    ps_send_s = 1'b1;
                    ps_en_s   = 1'b1;
                    busy_s    = 1'b1;
                    // The counter saturates instead of wrapping.
                    if (bit_cnt_r == 5'd31) begin
                        bit_cnt_s = bit_cnt_r;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                    if (last_bit_s) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_SHIFT;
                    end
                end
                S_DRAIN: begin
                    done_s  = 1'b1;
                    ps_en_s = 1'b1;
                    busy_s  = 1'b1;
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State, counter, captured request and output flops, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            bit_cnt_r  <= 5'd0;
            addr_r     <= '0;
            sel_r      <= 2'b00;
            mram_rd_r  <= 1'b0;
            ps_en_r    <= 1'b0;
            ps_load_r  <= 1'b0;
            ps_send_r  <= 1'b0;
            busy_r     <= 1'b0;
            tx_valid_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            mram_rd_r  <= mram_rd_s;
            ps_en_r    <= ps_en_s;
            ps_load_r  <= ps_load_s;
            ps_send_r  <= ps_send_s;
            busy_r     <= busy_s;
            tx_valid_r <= tx_valid_s;
            done_r     <= done_s;
            err_r      <= err_s;
            if (capture_s) begin
                addr_r <= req_addr;
                sel_r  <= req_word_sel;
            end else begin
                addr_r <= addr_r;
                sel_r  <= sel_r;
            end
        end
    end

    assign mram_rd     = mram_rd_r;
    assign mram_addr   = addr_r;
    assign ps_en       = ps_en_r;
    assign ps_load     = ps_load_r;
    assign ps_send     = ps_send_r;
    assign ps_word_sel = sel_r;
    assign busy        = busy_r;
    assign tx_valid    = tx_valid_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_serial_readout_ctrl.sv
// Directed testbench for serial_readout_ctrl.
// Cycle c of a window is the output state after edge E0+c, where E0 is the
// edge that samples the first request.
module tb_serial_readout_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [9:0] req_addr;
    logic [1:0] req_word_sel;
    logic       abort;
    logic       mram_rdy;
    logic       mram_rd;
    logic [9:0] mram_addr;
    logic       ps_en;
    logic       ps_load;
    logic       ps_send;
    logic [1:0] ps_word_sel;
    logic       busy;
    logic       tx_valid;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Per-window observations
    int n_load, n_send, n_tx, n_done, n_err, n_rd;
    int first_load, first_send, first_tx, first_done, last_done, first_err, first_rd, first_low;
    logic [1:0] sel_first_done, sel_last_done;
    logic snap_err, snap_busy, snap_send, snap_tx, snap_rd;
    logic last_rd, last_busy;

    serial_readout_ctrl #(.ADDR_W(10), .RD_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_word_sel(req_word_sel), .abort(abort), .mram_rdy(mram_rdy),
        .mram_rd(mram_rd), .mram_addr(mram_addr), .ps_en(ps_en),
        .ps_load(ps_load), .ps_send(ps_send), .ps_word_sel(ps_word_sel),
        .busy(busy), .tx_valid(tx_valid), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run ncyc cycles and record activity. The caller drives the edge-0
    // inputs first. Optionally a second request is sampled at edge req_at,
    // and abort is sampled at edge abort_at.
    task automatic run_window(input int ncyc, input int req_at, input logic [9:0] a2,
                              input logic [1:0] s2, input int abort_at);
        n_load = 0; n_send = 0; n_tx = 0; n_done = 0; n_err = 0; n_rd = 0;
        first_load = -1; first_send = -1; first_tx = -1; first_done = -1;
        last_done = -1; first_err = -1; first_rd = -1; first_low = -1;
        sel_first_done = 2'b00; sel_last_done = 2'b00;
        snap_err = 1'b0; snap_busy = 1'b0; snap_send = 1'b0; snap_tx = 1'b0; snap_rd = 1'b0;
        abort = (abort_at == 0);
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (ps_load)  begin n_load++; if (first_load < 0) first_load = c; end
            if (ps_send)  begin n_send++; if (first_send < 0) first_send = c; end
            if (tx_valid) begin n_tx++;   if (first_tx < 0)   first_tx = c;   end
            if (mram_rd)  begin n_rd++;   if (first_rd < 0)   first_rd = c;   end
            if (err)      begin n_err++;  if (first_err < 0)  first_err = c;  end
            if (done) begin
                n_done++;
                if (first_done < 0) begin first_done = c; sel_first_done = ps_word_sel; end
                last_done = c; sel_last_done = ps_word_sel;
            end
            if (!busy && first_low < 0) first_low = c;
            if (c == abort_at) begin
                snap_err = err; snap_busy = busy; snap_send = ps_send; snap_tx = tx_valid; snap_rd = mram_rd;
            end
            last_rd = mram_rd; last_busy = busy;
            req = 1'b0; abort = 1'b0;
            if (req_at == c + 1) begin req = 1'b1; req_addr = a2; req_word_sel = s2; end
            if (abort_at == c + 1) abort = 1'b1;
        end
        req = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; req_addr = 10'h000; req_word_sel = 2'b00;
        abort = 1'b0; mram_rdy = 1'b0;
        repeat (3) tick();
        checks++;
        if ({mram_rd, ps_en, ps_load, ps_send, busy, tx_valid, done, err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {mram_rd, ps_en, ps_load, ps_send, busy, tx_valid, done, err});
        end
        checks++;
        if ({mram_addr, ps_word_sel} !== 12'h000) begin
            errors++;
            $display("FAIL reset_addr_sel: got %h expected 000", {mram_addr, ps_word_sel});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_word(input logic [9:0] a);
        mram_rdy = 1'b1;
        req = 1'b1; req_addr = a; req_word_sel = 2'b11;
        run_window(24, -1, 10'h000, 2'b00, -1);
        checks++; if (mram_addr !== a) begin errors++; $display("FAIL full_addr: got %h expected %h", mram_addr, a); end
        checks++; if (first_rd !== 1) begin errors++; $display("FAIL full_first_rd: got %0d expected 1", first_rd); end
        checks++; if (n_load !== 1 || first_load !== 2) begin errors++; $display("FAIL full_load: got n=%0d at %0d expected n=1 at 2", n_load, first_load); end
        checks++; if (n_send !== 16 || first_send !== 3) begin errors++; $display("FAIL full_send: got n=%0d from %0d expected n=16 from 3", n_send, first_send); end
        checks++; if (n_tx !== 16 || first_tx !== 4) begin errors++; $display("FAIL full_tx: got n=%0d from %0d expected n=16 from 4", n_tx, first_tx); end
        checks++; if (n_done !== 1 || first_done !== 19) begin errors++; $display("FAIL full_done: got n=%0d at %0d expected n=1 at 19", n_done, first_done); end
        checks++; if (first_low !== 20) begin errors++; $display("FAIL full_busy_fall: got %0d expected 20", first_low); end
        checks++; if (sel_first_done !== 2'b11 || n_err !== 0) begin errors++; $display("FAIL full_sel_err: got sel=%b err=%0d expected sel=11 err=0", sel_first_done, n_err); end
    endtask

    task automatic test_back_to_back();
        mram_rdy = 1'b1;
        req = 1'b1; req_addr = 10'h0F0; req_word_sel = 2'b01;
        run_window(30, 12, 10'h00F, 2'b10, -1);
        checks++; if (n_send !== 16 || n_tx !== 16) begin errors++; $display("FAIL b2b_bits: got send=%0d tx=%0d expected 16 16", n_send, n_tx); end
        checks++; if (n_load !== 2) begin errors++; $display("FAIL b2b_load: got %0d expected 2", n_load); end
        checks++; if (n_done !== 2 || first_done !== 11 || last_done !== 23) begin errors++; $display("FAIL b2b_done: got n=%0d at %0d,%0d expected 2 at 11,23", n_done, first_done, last_done); end
        checks++; if (sel_first_done !== 2'b01 || sel_last_done !== 2'b10) begin errors++; $display("FAIL b2b_sel: got %b,%b expected 01,10", sel_first_done, sel_last_done); end
        checks++; if (first_low !== 24) begin errors++; $display("FAIL b2b_busy_gap: got first low %0d expected 24", first_low); end
        checks++; if (mram_addr !== 10'h00F) begin errors++; $display("FAIL b2b_addr: got %h expected 00f", mram_addr); end
    endtask

    task automatic test_illegal();
        mram_rdy = 1'b1;
        req = 1'b1; req_addr = 10'h3FF; req_word_sel = 2'b00;
        run_window(5, -1, 10'h000, 2'b00, -1);
        checks++; if (n_err !== 1 || first_err !== 0) begin errors++; $display("FAIL illegal_err: got n=%0d at %0d expected n=1 at 0", n_err, first_err); end
        checks++; if (first_low !== 0 || last_busy !== 1'b0) begin errors++; $display("FAIL illegal_busy: got first low %0d expected 0", first_low); end
        checks++; if (n_rd !== 0) begin errors++; $display("FAIL illegal_rd: got %0d expected 0", n_rd); end
    endtask

    task automatic test_overlap();
        mram_rdy = 1'b1;
        req = 1'b1; req_addr = 10'h100; req_word_sel = 2'b11;
        run_window(24, 6, 10'h2AA, 2'b01, -1);
        checks++; if (mram_addr !== 10'h100) begin errors++; $display("FAIL overlap_addr: got %h expected 100", mram_addr); end
        checks++; if (n_done !== 1 || first_done !== 19 || sel_first_done !== 2'b11) begin errors++; $display("FAIL overlap_done: got n=%0d at %0d sel=%b expected 1 at 19 sel=11", n_done, first_done, sel_first_done); end
        checks++; if (n_send !== 16 || n_load !== 1) begin errors++; $display("FAIL overlap_bits: got send=%0d load=%0d expected 16 1", n_send, n_load); end
    endtask

    task automatic test_abort();
        mram_rdy = 1'b1;
        req = 1'b1; req_addr = 10'h0AB; req_word_sel = 2'b11;
        run_window(25, -1, 10'h000, 2'b00, 8);
        checks++; if ({snap_err, snap_busy, snap_send, snap_tx} !== 4'b1000) begin errors++; $display("FAIL abort_snap: got err,busy,send,tx=%b expected 1000", {snap_err, snap_busy, snap_send, snap_tx}); end
        checks++; if (n_done !== 0 || n_err !== 1) begin errors++; $display("FAIL abort_done_err: got done=%0d err=%0d expected 0 1", n_done, n_err); end
        checks++; if (n_send !== 5 || n_tx !== 4) begin errors++; $display("FAIL abort_bits: got send=%0d tx=%0d expected 5 4", n_send, n_tx); end
        test_full_word(10'h155);
    endtask

    task automatic test_abort_read();
        mram_rdy = 1'b1;
        req = 1'b1; req_addr = 10'h033; req_word_sel = 2'b10;
        run_window(6, -1, 10'h000, 2'b00, 1);
        checks++; if (snap_err !== 1'b1 || snap_busy !== 1'b0 || snap_rd !== 1'b0) begin errors++; $display("FAIL abort_read_snap: got err=%b busy=%b rd=%b expected 1 0 0", snap_err, snap_busy, snap_rd); end
        checks++; if (n_load !== 0 || n_rd !== 0) begin errors++; $display("FAIL abort_read_load: got load=%0d rd=%0d expected 0 0", n_load, n_rd); end
    endtask

    task automatic test_abort_idle();
        req = 1'b0;
        run_window(4, -1, 10'h000, 2'b00, 0);
        checks++; if (n_err !== 0 || first_low !== 0) begin errors++; $display("FAIL abort_idle: got err=%0d first low %0d expected 0 0", n_err, first_low); end
    endtask

    task automatic test_timeout();
        mram_rdy = 1'b0;
        req = 1'b1; req_addr = 10'h011; req_word_sel = 2'b11;
`ifdef SERIAL_READOUT_TIMEOUT_EN
        run_window(20, -1, 10'h000, 2'b00, -1);
        checks++; if (first_rd !== 1 || n_rd !== 14) begin errors++; $display("FAIL timeout_rd: got first=%0d n=%0d expected 1 14", first_rd, n_rd); end
        checks++; if (n_err !== 1 || first_err !== 15) begin errors++; $display("FAIL timeout_err: got n=%0d at %0d expected 1 at 15", n_err, first_err); end
        checks++; if (n_load !== 0 || first_low !== 15) begin errors++; $display("FAIL timeout_exit: got load=%0d low at %0d expected 0 15", n_load, first_low); end
`else
        run_window(101, -1, 10'h000, 2'b00, -1);
        checks++; if (n_rd !== 100 || last_rd !== 1'b1) begin errors++; $display("FAIL wait_rd: got n=%0d last=%b expected 100 1", n_rd, last_rd); end
        checks++; if (last_busy !== 1'b1 || n_load !== 0 || n_err !== 0) begin errors++; $display("FAIL wait_state: got busy=%b load=%0d err=%0d expected 1 0 0", last_busy, n_load, n_err); end
        req = 1'b0;
        run_window(3, -1, 10'h000, 2'b00, 0);
        checks++; if (snap_err !== 1'b1 || snap_busy !== 1'b0 || snap_rd !== 1'b0) begin errors++; $display("FAIL wait_abort: got err=%b busy=%b rd=%b expected 1 0 0", snap_err, snap_busy, snap_rd); end
`endif
        mram_rdy = 1'b1;
    endtask

    task automatic test_reset_mid();
        mram_rdy = 1'b1;
        req = 1'b1; req_addr = 10'h1C3; req_word_sel = 2'b11;
        tick();
        req = 1'b0;
        repeat (5) tick();
        checks++; if (ps_send !== 1'b1) begin errors++; $display("FAIL rstmid_shift: got ps_send=%b expected 1", ps_send); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({mram_rd, ps_en, ps_load, ps_send, busy, tx_valid, done, err, mram_addr, ps_word_sel} !== 20'h00000) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h expected 00000",
                     {mram_rd, ps_en, ps_load, ps_send, busy, tx_valid, done, err, mram_addr, ps_word_sel});
        end
        run_window(20, -1, 10'h000, 2'b00, -1);
        checks++; if (n_done !== 0 || n_err !== 0 || n_send !== 0 || first_low !== 0) begin errors++; $display("FAIL rstmid_quiet: got done=%0d err=%0d send=%0d low=%0d expected 0 0 0 0", n_done, n_err, n_send, first_low); end
        test_full_word(10'h2C5);
    endtask

    initial begin
        test_reset();
        test_full_word(10'h155);
        test_back_to_back();
        test_illegal();
        test_overlap();
        test_abort();
        test_abort_read();
        test_abort_idle();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_readout_ctrl.md
# serial_readout_ctrl

Sequencer for the MRAM read path and the 16-bit parallel-to-serial shifter. It accepts one readout request at a time, reads a word from MRAM, and pulses the shifter's load. It then drives exactly 16 or 8 shift cycles, depending on the selected word, and flags which `data_out` cycles carry valid serial bits. It sits between the host command logic and the shifter and owns every shifter control input.

## Interface
- `ADDR_W`, default 10: MRAM address width.
- `RD_TIMEOUT`, default 15: maximum cycles spent in READ waiting for `mram_rdy` (only used with timeout compiled in).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 1: readout request; sampled only in IDLE.
- `req_addr` in ADDR_W: word address, captured with `req`.
- `req_word_sel` in 2: 11 selects the full word, 01 the lower byte, 10 the upper byte, 00 is illegal. Captured with `req`.
- `abort` in 1: cancel the current transaction.
- `mram_rdy` in 1: MRAM read data valid on the shifter's data input.
- `mram_rd` out 1: MRAM read strobe, held high for all of READ.
- `mram_addr` out ADDR_W: the captured address.
- `ps_en` out 1: shifter enable.
- `ps_load` out 1: shifter load pulse.
- `ps_send` out 1: shifter shift strobe.
- `ps_word_sel` out 2: the captured word select.
- `busy` out 1: high in every state except IDLE.
- `tx_valid` out 1: the shifter's `data_out` holds a valid bit this cycle.
- `done` out 1: one-cycle pulse coinciding with the last valid bit.
- `err` out 1: one-cycle pulse for an illegal request, an abort or a timeout.

## Operation
- All outputs are registered. The reset value of every output is 0, and the state after reset is IDLE.
- State machine: IDLE → READ → LOAD → SHIFT → DRAIN → IDLE.
- **IDLE**
  - On `req` with a legal `req_word_sel`: capture address and word select, then go to READ.
  - On `req` with `req_word_sel` = 00: pulse `err` and stay in IDLE.
- **READ**
  - Outputs: `mram_rd`=1, `ps_en`=1.
  - On `mram_rdy`=1: go to LOAD.
- **LOAD**
  - Outputs: `ps_load`=1 for exactly one cycle, `mram_rd`=0.
  - Bit counter cleared to 0.
- **SHIFT**
  - Output: `ps_send`=1 every cycle.
  - Counter increments each cycle.
  - Bit count N is 16 for word select 11 and 8 for 01 or 10.
  - Leave SHIFT after N cycles; the counter is 5 bits and never wraps.
- **DRAIN**
  - Outputs: `ps_send`=0, `tx_valid`=1, `done`=1.
  - The next state is IDLE.
- `tx_valid` is `ps_send` delayed by one cycle, because the shifter registers `data_out`. It is therefore high for exactly N consecutive cycles, the last of which is DRAIN.
- `ps_en` is high in READ, LOAD, SHIFT and DRAIN, and low in IDLE.
- `ps_word_sel` holds the captured value from LOAD through DRAIN.
- **Boundary conditions**
  - `req` while `busy`: ignored. There is no queueing, and the captured address and word select do not change.
  - `abort` in any non-IDLE state: go to IDLE on the next edge. In that cycle `err`=1, and `done`, `ps_send`, `ps_load` and `mram_rd` are all 0. `tx_valid` goes low on the same edge, so the in-flight bit is discarded.
  - `abort` together with `mram_rdy`: abort wins.
  - `abort` in IDLE: no effect, no `err`.
  - `mram_rdy` outside READ: ignored.
  - `rst_n`=0 mid-transaction: the next edge forces IDLE and all outputs to 0. No `done` or `err` is produced.

## Timing
- `req` sampled at edge E0 → `mram_rd`=1 from E0+1.
- `mram_rdy` sampled high at edge Er → `ps_load`=1 for the cycle Er+1..Er+2.
- `ps_send` is high from Er+2 for N cycles.
- `tx_valid` is high from Er+3 through Er+2+N, which is the DRAIN cycle. `done` is also high in that DRAIN cycle.
- `busy` falls at Er+3+N. A new `req` can be sampled at that same edge, giving back-to-back transactions with no idle cycle of `busy`.
- With `mram_rdy` already high at E0+1, the total latency from `req` to `done` is N+3 cycles.

## Configuration
- Macro: `SERIAL_READOUT_TIMEOUT_EN`.
- **Defined:** a 4-bit-or-wider counter runs in READ. If `mram_rdy` has not arrived after `RD_TIMEOUT` cycles in READ, the block pulses `err` and returns to IDLE with `mram_rd` dropped. `mram_rdy` on the expiry cycle still wins.
- **Undefined:** READ waits for `mram_rdy` indefinitely, no timeout counter is built, and `RD_TIMEOUT` is unused.

## Test plan
- **Full word, MRAM ready immediately:** `req`, addr 0x155, word select 11, `mram_rdy` tied high.
  - `mram_addr`=0x155.
  - One `ps_load` pulse.
  - `ps_send` high for 16 cycles, then `tx_valid` high for 16 cycles.
  - `done` high on the 16th `tx_valid`, 19 cycles after `req`; `busy` is 0 on the next cycle.
- **Lower byte, then upper byte, back-to-back:** word select 01, then 10 issued at the edge where `busy` falls.
  - Each transaction gives 8 `ps_send` cycles and 8 `tx_valid` cycles.
  - The second `ps_word_sel` is 10.
  - There are two `done` pulses.
- **Illegal and overlapping requests:**
  - A `req` with word select 00 produces `err`=1 for one cycle, `busy` stays 0, and `mram_rd` never rises.
  - A `req` with addr 0x2AA during SHIFT leaves `mram_addr` unchanged.
- **Abort:** assert `abort` on the 5th SHIFT cycle of a full-word transfer.
  - The next cycle shows `err`=1, `busy`=0, `ps_send`=0 and `tx_valid`=0.
  - `done` is never asserted.
  - A following legal `req` completes normally.
- **Timeout, with `SERIAL_READOUT_TIMEOUT_EN` defined and `RD_TIMEOUT`=15:** hold `mram_rdy` low.
  - The block leaves READ after 15 cycles with one `err` pulse and `ps_load` never asserted.
  - Without the macro, `mram_rd` stays high after 100 cycles.
- **Reset mid-transfer:** hold `rst_n`=0 for one edge during SHIFT.
  - Every output is 0 after that edge and the state is IDLE.
  - There is no `done` or `err` pulse.
